// File: rtl/sample_iterator.sv
// rtl/sample_iterator.sv - raster-order sample generator over a triangle bounding box
module sample_iterator #(
    parameter int SIGFIG = 24,
    parameter int RADIX  = 10,
    parameter int VERTS  = 3,
    parameter int AXIS   = 3,
    parameter int COLORS = 3
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic signed [SIGFIG-1:0] tri_R13S [VERTS][AXIS],
    input  logic        [SIGFIG-1:0] color_R13U [COLORS],
    input  logic signed [SIGFIG-1:0] box_R13S [2][2],
    input  logic                     validTri_R13H,
    input  logic        [3:0]        subSample_RnnnnU,
    output logic                     halt_RnnnnL,
    output logic signed [SIGFIG-1:0] tri_R14S [VERTS][AXIS],
    output logic        [SIGFIG-1:0] color_R14U [COLORS],
    output logic signed [SIGFIG-1:0] sample_R14S [2],
    output logic                     validSamp_R14H
);

    typedef enum logic {WAIT, TEST} state_t;

    state_t                  state, state_nxt;
    logic signed [SIGFIG-1:0] ll_x, ll_y, ur_x, ur_y;
    logic signed [SIGFIG:0]   step;
    logic signed [SIGFIG:0]   x_ext, y_ext, ur_x_ext, ur_y_ext;
    logic signed [SIGFIG:0]   next_x, next_y;
    logic                     box_ok, accept, adv_x, adv_y;

    always_comb begin
        step = '0;
        case (subSample_RnnnnU)
            4'b0100: step[RADIX-1] = 1'b1;
            4'b0010: step[RADIX-2] = 1'b1;
            4'b0001: step[RADIX-3] = 1'b1;
            default: step[RADIX]   = 1'b1;
        endcase
    end

    // One extra bit keeps step additions and corner compares overflow-free.
    assign x_ext    = {sample_R14S[0][SIGFIG-1], sample_R14S[0]};
    assign y_ext    = {sample_R14S[1][SIGFIG-1], sample_R14S[1]};
    assign ur_x_ext = {ur_x[SIGFIG-1], ur_x};
    assign ur_y_ext = {ur_y[SIGFIG-1], ur_y};
    assign next_x   = x_ext + step;
    assign next_y   = y_ext + step;
    assign adv_x    = (next_x <= ur_x_ext);
    assign adv_y    = (next_y <= ur_y_ext);

    assign box_ok = (box_R13S[1][0] >= box_R13S[0][0]) && (box_R13S[1][1] >= box_R13S[0][1]);
    assign accept = (state == WAIT) && validTri_R13H && box_ok;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= WAIT;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt   = state;
        halt_RnnnnL = 1'b1;
        case (state)
            WAIT: if (accept) state_nxt = TEST;
            TEST: begin
                halt_RnnnnL = 1'b0;
                if (!adv_x && !adv_y) state_nxt = WAIT;
            end
            default: state_nxt = WAIT;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            validSamp_R14H <= 1'b0;
            sample_R14S[0] <= '0;
            sample_R14S[1] <= '0;
            ll_x           <= '0;
            ll_y           <= '0;
            ur_x           <= '0;
            ur_y           <= '0;
            for (int v = 0; v < VERTS; v++)
                for (int a = 0; a < AXIS; a++)
                    tri_R14S[v][a] <= '0;
            for (int c = 0; c < COLORS; c++)
                color_R14U[c] <= '0;
        end else if (accept) begin
            tri_R14S       <= tri_R13S;
            color_R14U     <= color_R13U;
            ll_x           <= box_R13S[0][0];
            ll_y           <= box_R13S[0][1];
            ur_x           <= box_R13S[1][0];
            ur_y           <= box_R13S[1][1];
            sample_R14S[0] <= box_R13S[0][0];
            sample_R14S[1] <= box_R13S[0][1];
            validSamp_R14H <= 1'b1;
        end else if (state == TEST) begin
            if (adv_x) begin
                sample_R14S[0] <= next_x[SIGFIG-1:0];
            end else if (adv_y) begin
                sample_R14S[0] <= ll_x;
                sample_R14S[1] <= next_y[SIGFIG-1:0];
            end else begin
                validSamp_R14H <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_sample_iterator.sv
// tb/tb_sample_iterator.sv - scoreboard bench for sample_iterator
module tb_sample_iterator;

    logic               clk = 1'b0;
    logic               rst;
    logic signed [23:0] tri_in [3][3];
    logic        [23:0] color_in [3];
    logic signed [23:0] box_in [2][2];
    logic               valid_in;
    logic        [3:0]  sub_in;
    logic               halt;
    logic signed [23:0] tri_out [3][3];
    logic        [23:0] color_out [3];
    logic signed [23:0] samp [2];
    logic               vsamp;

    int          checks   = 0;
    int          failures = 0;
    int          cyc      = 0;
    logic [47:0] sbq [$];

    sample_iterator dut (
        .clk              (clk),
        .rst              (rst),
        .tri_R13S         (tri_in),
        .color_R13U       (color_in),
        .box_R13S         (box_in),
        .validTri_R13H    (valid_in),
        .subSample_RnnnnU (sub_in),
        .halt_RnnnnL      (halt),
        .tri_R14S         (tri_out),
        .color_R14U       (color_out),
        .sample_R14S      (samp),
        .validSamp_R14H   (vsamp)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic present(input int lx, input int ly, input int ux, input int uy,
                           input logic [3:0] sub, input int tv);
        int st;
        box_in[0][0] = 24'(lx);
        box_in[0][1] = 24'(ly);
        box_in[1][0] = 24'(ux);
        box_in[1][1] = 24'(uy);
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_in[v][a] = 24'(tv + v * 3 + a);
        for (int c = 0; c < 3; c++)
            color_in[c] = 24'(tv + 100 + c);
        sub_in   = sub;
        valid_in = 1'b1;
        case (sub)
            4'b0100: st = 512;
            4'b0010: st = 256;
            4'b0001: st = 128;
            default: st = 1024;
        endcase
        for (int y = ly; y <= uy; y += st)
            for (int x = lx; x <= ux; x += st)
                sbq.push_back({24'(x), 24'(y)});
    endtask

    task automatic drain(input int budget, output int n, output int first_c, output int last_c);
        logic [47:0] exp;
        n = 0; first_c = -1; last_c = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (vsamp) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_sample got=(%0d,%0d) expected none", samp[0], samp[1]);
                end else begin
                    exp = sbq.pop_front();
                    if ({samp[0], samp[1]} !== exp) begin
                        failures++;
                        $display("FAIL sample got=(%0d,%0d) expected=(%0d,%0d)", samp[0], samp[1],
                                 $signed(exp[47:24]), $signed(exp[23:0]));
                    end
                end
                checks++;
                if (halt !== 1'b0) begin
                    failures++;
                    $display("FAIL halt_during_scan got=%b expected=0", halt);
                end
                n++;
                if (first_c < 0) first_c = cyc;
                last_c = cyc;
            end else if (n > 0) begin
                break;
            end
        end
        checks++;
        if (sbq.size() != 0) begin
            failures++;
            $display("FAIL missing_samples got=%0d left expected=0", sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (halt !== 1'b1 || vsamp !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl got halt=%b valid=%b expected halt=1 valid=0", halt, vsamp);
        end
        checks++;
        if (samp[0] !== 24'd0 || samp[1] !== 24'd0 || tri_out[1][2] !== 24'd0 || color_out[2] !== 24'd0) begin
            failures++;
            $display("FAIL reset_data got samp=(%0d,%0d) tri=%0d color=%0d expected all 0",
                     samp[0], samp[1], tri_out[1][2], color_out[2]);
        end
        rst = 1'b1;
    endtask

    task automatic test_full_pixel();
        int n, f, l, acc, bad;
        @(negedge clk);
        present(0, 0, 2048, 1024, 4'b1000, 10);
        acc = cyc + 1;
        @(posedge clk); #1 valid_in = 1'b0;
        drain(40, n, f, l);
        checks++;
        if (n != 6 || f != acc || l != acc + 5) begin
            failures++;
            $display("FAIL full_timing got n=%0d first=%0d last=%0d expected n=6 first=%0d last=%0d",
                     n, f, l, acc, acc + 5);
        end
        checks++;
        if (halt !== 1'b1 || vsamp !== 1'b0) begin
            failures++;
            $display("FAIL full_end got halt=%b valid=%b expected halt=1 valid=0", halt, vsamp);
        end
        bad = 0;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                if (tri_out[v][a] !== 24'(10 + v * 3 + a)) bad++;
        for (int c = 0; c < 3; c++)
            if (color_out[c] !== 24'(110 + c)) bad++;
        checks++;
        if (bad != 0) begin
            failures++;
            $display("FAIL tri_color_latch got %0d wrong fields expected 0", bad);
        end
    endtask

    task automatic test_half_pixel();
        int n, f, l;
        @(negedge clk);
        present(512, 512, 1536, 1024, 4'b0100, 20);
        @(posedge clk); #1 valid_in = 1'b0;
        drain(40, n, f, l);
        checks++;
        if (n != 6) begin
            failures++;
            $display("FAIL half_count got=%0d expected=6", n);
        end
    endtask

    task automatic test_degenerate();
        int n, f, l;
        @(negedge clk);
        present(-3072, 5120, -3072, 5120, 4'b1000, 30);
        @(posedge clk); #1 valid_in = 1'b0;
        drain(20, n, f, l);
        checks++;
        if (n != 1 || halt !== 1'b1) begin
            failures++;
            $display("FAIL degenerate got n=%0d halt=%b expected n=1 halt=1", n, halt);
        end
    endtask

    task automatic test_inverted();
        @(negedge clk);
        present(2048, 0, 1024, 0, 4'b1000, 40);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            checks++;
            if (vsamp !== 1'b0 || halt !== 1'b1) begin
                failures++;
                $display("FAIL inverted got valid=%b halt=%b expected valid=0 halt=1", vsamp, halt);
            end
        end
        checks++;
        if (tri_out[0][0] !== 24'd30) begin
            failures++;
            $display("FAIL inverted_latch got tri=%0d expected=30", tri_out[0][0]);
        end
        valid_in = 1'b0;
        sbq.delete();
    endtask

    task automatic test_back_to_back();
        logic [47:0] exp;
        int k, c1, c2;
        k = 0; c1 = -100; c2 = 0;
        @(negedge clk);
        present(0, 0, 1024, 0, 4'b1000, 50);
        @(posedge clk); #1;
        present(-512, -512, -512, 512, 4'b1000, 60);
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (vsamp) begin
                checks++;
                if (sbq.size() == 0) begin
                    failures++;
                    $display("FAIL b2b_extra got=(%0d,%0d) expected none", samp[0], samp[1]);
                end else begin
                    exp = sbq.pop_front();
                    if ({samp[0], samp[1]} !== exp) begin
                        failures++;
                        $display("FAIL b2b_sample got=(%0d,%0d) expected=(%0d,%0d)", samp[0], samp[1],
                                 $signed(exp[47:24]), $signed(exp[23:0]));
                    end
                end
                if (k == 1) c1 = cyc;
                if (k == 2) begin
                    c2 = cyc;
                    checks++;
                    if (tri_out[0][0] !== 24'd60) begin
                        failures++;
                        $display("FAIL b2b_tri2 got=%0d expected=60", tri_out[0][0]);
                    end
                    valid_in = 1'b0;
                end
                if (k == 1) begin
                    checks++;
                    if (tri_out[0][0] !== 24'd50) begin
                        failures++;
                        $display("FAIL b2b_tri1 got=%0d expected=50", tri_out[0][0]);
                    end
                end
                k++;
            end
        end
        valid_in = 1'b0;
        checks++;
        if (k != 4 || c2 - c1 != 2 || sbq.size() != 0) begin
            failures++;
            $display("FAIL b2b got samples=%0d gap=%0d left=%0d expected samples=4 gap=2 left=0",
                     k, c2 - c1, sbq.size());
        end
        sbq.delete();
    endtask

    task automatic test_reset_mid_scan();
        logic [47:0] exp;
        int n, f, l, acc;
        @(negedge clk);
        present(0, 0, 2048, 2048, 4'b1000, 70);
        @(posedge clk); #1 valid_in = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            exp = sbq.pop_front();
            checks++;
            if (vsamp !== 1'b1 || {samp[0], samp[1]} !== exp) begin
                failures++;
                $display("FAIL mid_sample got valid=%b (%0d,%0d) expected valid=1 (%0d,%0d)", vsamp,
                         samp[0], samp[1], $signed(exp[47:24]), $signed(exp[23:0]));
            end
        end
        sbq.delete();
        rst = 1'b0;
        #1;
        checks++;
        if (vsamp !== 1'b0 || halt !== 1'b1 || samp[0] !== 24'd0 || tri_out[0][0] !== 24'd0) begin
            failures++;
            $display("FAIL async_reset got valid=%b halt=%b x=%0d tri=%0d expected 0 1 0 0",
                     vsamp, halt, samp[0], tri_out[0][0]);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (vsamp !== 1'b0) begin
                failures++;
                $display("FAIL reset_hold got valid=%b expected=0", vsamp);
            end
        end
        rst = 1'b1;
        present(1024, -1024, 1024, -1024, 4'b1000, 80);
        acc = cyc + 1;
        @(posedge clk); #1 valid_in = 1'b0;
        drain(20, n, f, l);
        checks++;
        if (n != 1 || f != acc) begin
            failures++;
            $display("FAIL post_reset got n=%0d first=%0d expected n=1 first=%0d", n, f, acc);
        end
    endtask

    initial begin
        valid_in = 1'b0;
        sub_in   = 4'b1000;
        for (int v = 0; v < 3; v++)
            for (int a = 0; a < 3; a++)
                tri_in[v][a] = '0;
        for (int c = 0; c < 3; c++) color_in[c] = '0;
        for (int i = 0; i < 2; i++) begin
            box_in[i][0] = '0;
            box_in[i][1] = '0;
        end
        test_reset();
        test_full_pixel();
        test_half_pixel();
        test_degenerate();
        test_inverted();
        test_back_to_back();
        test_reset_mid_scan();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
